// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    StPwrup,
    StInitLoad,
    StIdle,
    StSetup,
    StEnHigh,
    StHold,
    StExecWait
  } lcd_state_t;

  localparam int unsigned LCD_INIT_LEN = 4;
  // Function set 8-bit/2-line, display on, clear, entry mode increment.
  localparam logic [7:0] LCD_INIT_SEQ [LCD_INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  localparam logic [7:0] LCD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_HOME  = 8'h02;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Clear and return-home need the long execution wait; 0x03 is home with its
  // don't-care bit set.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == LCD_CLEAR || data == LCD_HOME || data == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; done while the count sits at zero.
module lcd_timer #(
  parameter int unsigned Width    = 8,
  parameter int unsigned ResetVal = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             done_o
);

  logic [Width-1:0] count_q;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= Width'(ResetVal);
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// Timed HD44780 write controller with self-run power-up initialisation.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned EN_CYC    = 12,
  parameter int unsigned HOLD_CYC  = 4,
  parameter int unsigned EXEC_CYC  = 2000,
  parameter int unsigned CLEAR_CYC = 82000,
  parameter int unsigned PWRUP_CYC = 750000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  input  logic        i_cmd_rs,
  input  logic [7:0]  i_cmd_data,
  output logic        o_cmd_ready,
  input  logic        i_lcd_on,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic [31:0] o_status
);

  localparam int unsigned MaxCyc = max_u(max_u(max_u(SETUP_CYC, EN_CYC), max_u(HOLD_CYC, EXEC_CYC)),
                                         max_u(CLEAR_CYC, PWRUP_CYC));
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);
  localparam int unsigned IdxW   = $clog2(LCD_INIT_LEN);

  lcd_state_t      state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic            rs_q, rs_d;
  logic            en_q;
  logic            on_q;
  logic            init_done_q, init_done_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            tmr_load;
  logic [CntW-1:0] tmr_val;
  logic            tmr_done;

  lcd_timer #(
    .Width    (CntW),
    .ResetVal (PWRUP_CYC - 1)
  ) u_timer (
    .clk_i      (i_clk),
    .rst_ni     (i_reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Next state, bus latch and timer reloads; each timed state runs N cycles.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    rs_d        = rs_q;
    init_done_d = init_done_q;
    idx_d       = idx_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    case (state_q)
      StPwrup: begin
        if (tmr_done) state_d = StInitLoad;
      end
      StInitLoad: begin
        data_d   = LCD_INIT_SEQ[idx_q];
        rs_d     = 1'b0;
        state_d  = StSetup;
        tmr_load = 1'b1;
        tmr_val  = CntW'(SETUP_CYC - 1);
      end
      StIdle: begin
        if (i_cmd_valid && init_done_q) begin
          data_d   = i_cmd_data;
          rs_d     = i_cmd_rs;
          state_d  = StSetup;
          tmr_load = 1'b1;
          tmr_val  = CntW'(SETUP_CYC - 1);
        end
      end
      StSetup: begin
        if (tmr_done) begin
          state_d  = StEnHigh;
          tmr_load = 1'b1;
          tmr_val  = CntW'(EN_CYC - 1);
        end
      end
      StEnHigh: begin
        if (tmr_done) begin
          state_d  = StHold;
          tmr_load = 1'b1;
          tmr_val  = CntW'(HOLD_CYC - 1);
        end
      end
      StHold: begin
        if (tmr_done) begin
          state_d  = StExecWait;
          tmr_load = 1'b1;
          tmr_val  = is_long_cmd(rs_q, data_q) ? CntW'(CLEAR_CYC - 1) : CntW'(EXEC_CYC - 1);
        end
      end
      StExecWait: begin
        if (tmr_done) begin
          if (init_done_q) begin
            state_d = StIdle;
          end else if (idx_q == IdxW'(LCD_INIT_LEN - 1)) begin
            init_done_d = 1'b1;
            state_d     = StIdle;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StInitLoad;
          end
        end
      end
      default: begin
        state_d  = StPwrup;
        tmr_load = 1'b1;
        tmr_val  = CntW'(PWRUP_CYC - 1);
      end
    endcase
  end

  // State and registered LCD pins; EN is high exactly while in StEnHigh.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= StPwrup;
      data_q      <= '0;
      rs_q        <= 1'b0;
      en_q        <= 1'b0;
      on_q        <= 1'b0;
      init_done_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      en_q        <= (state_d == StEnHigh);
      on_q        <= i_lcd_on;
      init_done_q <= init_done_d;
      idx_q       <= idx_d;
    end
  end

  assign o_cmd_ready = (state_q == StIdle) && init_done_q;
  assign o_lcd_data  = data_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_en    = en_q;
  assign o_lcd_on    = on_q;
  assign o_status    = {30'b0, init_done_q, ~o_cmd_ready};

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl with shortened timing.
module tb_lcd_ctrl;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_cmd_valid;
  logic        i_cmd_rs;
  logic [7:0]  i_cmd_data;
  logic        o_cmd_ready;
  logic        i_lcd_on;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic        o_lcd_en;
  logic        o_lcd_on;
  logic [31:0] o_status;

  int cyc     = 0;
  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rise;
    int         fall;
  } exp_t;

  exp_t sb[$];

  lcd_ctrl #(
    .SETUP_CYC (2),
    .EN_CYC    (3),
    .HOLD_CYC  (2),
    .EXEC_CYC  (10),
    .CLEAR_CYC (40),
    .PWRUP_CYC (20)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_cmd_valid (i_cmd_valid),
    .i_cmd_rs    (i_cmd_rs),
    .i_cmd_data  (i_cmd_data),
    .o_cmd_ready (o_cmd_ready),
    .i_lcd_on    (i_lcd_on),
    .o_lcd_data  (o_lcd_data),
    .o_lcd_rs    (o_lcd_rs),
    .o_lcd_rw    (o_lcd_rw),
    .o_lcd_en    (o_lcd_en),
    .o_lcd_on    (o_lcd_on),
    .o_status    (o_status)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc is the number of posedges so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected pulse for a command accepted/loaded at edge e0: EN high e0+2 .. e0+5.
  task automatic push(input logic rs, input logic [7:0] d, input int e0);
    sb.push_back('{rs, d, e0 + 2, e0 + 5});
  endtask

  // Monitor: every EN pulse must match the head of the scoreboard.
  logic       prev_en = 1'b0;
  int         exp_fall = 0;
  logic [7:0] cur_data = 8'h00;
  always @(negedge clk) begin
    exp_t it;
    if (o_lcd_en && !prev_en) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_en_pulse: got data 0x%0h rs %0d, expected no pulse (cycle %0d)",
                 o_lcd_data, o_lcd_rs, cyc);
      end else begin
        it = sb.pop_front();
        check("en_rise_data", {24'h0, o_lcd_data}, {24'h0, it.data});
        check("en_rise_rs", {31'h0, o_lcd_rs}, {31'h0, it.rs});
        check("en_rise_rw", {31'h0, o_lcd_rw}, 32'h0);
        check("en_rise_cyc", cyc, it.rise);
        exp_fall <= it.fall;
        cur_data <= it.data;
      end
    end else if (o_lcd_en) begin
      check("en_data_stable", {24'h0, o_lcd_data}, {24'h0, cur_data});
    end else if (prev_en && i_reset) begin
      check("en_fall_cyc", cyc, exp_fall);
    end
    prev_en <= o_lcd_en;
  end

  task automatic wait_ready(input int bound);
    int k = 0;
    while (!o_cmd_ready && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (!o_cmd_ready) check("ready_timeout", {31'h0, o_cmd_ready}, 32'h1);
  endtask

  task automatic wait_ready_at(input int exp_cyc);
    wait_ready(200);
    check("ready_return_cyc", cyc, exp_cyc);
  endtask

  // Release reset, poke valid/lcd_on during init, then expect four init pulses.
  task automatic power_up();
    int  r;
    logic on_new;
    r = cyc;
    i_reset = 1'b1;
    // Load edges: r+21, r+39, r+57 (after the 40-cycle clear wait) ... r+105.
    push(1'b0, 8'h38, r + 21);
    push(1'b0, 8'h0C, r + 39);
    push(1'b0, 8'h01, r + 57);
    push(1'b0, 8'h06, r + 105);
    for (int i = 0; i < 30; i++) begin
      on_new      = ((i / 3) % 2) == 1;
      i_lcd_on    = on_new;
      i_cmd_valid = (i % 7) == 3;
      i_cmd_rs    = 1'b1;
      i_cmd_data  = 8'h55;
      @(negedge clk);
      check("lcd_on_follow", {31'h0, o_lcd_on}, {31'h0, on_new});
      check("init_status_busy", o_status, 32'h1);
    end
    i_cmd_valid = 1'b0;
    for (int k = 0; k < 300 && o_status != 32'h2; k++) @(negedge clk);
    check("init_done_status", o_status, 32'h2);
    check("init_done_cyc", cyc, r + 122);
  endtask

  task automatic send(input logic rs, input logic [7:0] d, input int lat);
    int e0;
    wait_ready(500);
    i_cmd_valid = 1'b1;
    i_cmd_rs    = rs;
    i_cmd_data  = d;
    e0 = cyc + 1;
    push(rs, d, e0);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    check("ready_drop", {31'h0, o_cmd_ready}, 32'h0);
    check("bus_latched", {23'h0, o_lcd_rs, o_lcd_data}, {23'h0, rs, d});
    wait_ready_at(e0 + lat);
  endtask

  // Valid held high across a busy window: one pulse per ready window.
  task automatic held_valid();
    int e0;
    wait_ready(500);
    i_cmd_valid = 1'b1;
    i_cmd_rs    = 1'b1;
    i_cmd_data  = 8'h41;
    e0 = cyc + 1;
    push(1'b1, 8'h41, e0);
    @(negedge clk);
    i_cmd_data = 8'h42;
    while (cyc < e0 + 17) begin
      check("held_data_0x41", {24'h0, o_lcd_data}, 32'h41);
      check("held_busy", {31'h0, o_cmd_ready}, 32'h0);
      @(negedge clk);
    end
    check("held_ready_rise", {31'h0, o_cmd_ready}, 32'h1);
    push(1'b1, 8'h42, e0 + 18);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    check("held_data_0x42", {24'h0, o_lcd_data}, 32'h42);
    check("held_busy_again", {31'h0, o_cmd_ready}, 32'h0);
    wait_ready_at(e0 + 35);
  endtask

  // Reset asserted while EN is high drops everything without a clock edge.
  task automatic reset_mid_en();
    int e0;
    int k = 0;
    wait_ready(500);
    i_cmd_valid = 1'b1;
    i_cmd_rs    = 1'b1;
    i_cmd_data  = 8'h43;
    e0 = cyc + 1;
    push(1'b1, 8'h43, e0);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    while (!o_lcd_en && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("en_before_reset", {31'h0, o_lcd_en}, 32'h1);
    #1 i_reset = 1'b0;
    #1;
    check("rst_async_en", {31'h0, o_lcd_en}, 32'h0);
    check("rst_async_status", o_status, 32'h1);
    check("rst_async_bus", {23'h0, o_lcd_rs, o_lcd_data}, 32'h0);
    check("rst_async_ready", {31'h0, o_cmd_ready}, 32'h0);
    repeat (3) @(negedge clk);
    power_up();
  endtask

  initial begin
    i_reset     = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_rs    = 1'b0;
    i_cmd_data  = 8'h00;
    i_lcd_on    = 1'b0;
    #2 i_reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_data", {24'h0, o_lcd_data}, 32'h0);
    check("reset_rs", {31'h0, o_lcd_rs}, 32'h0);
    check("reset_rw", {31'h0, o_lcd_rw}, 32'h0);
    check("reset_en", {31'h0, o_lcd_en}, 32'h0);
    check("reset_lcd_on", {31'h0, o_lcd_on}, 32'h0);
    check("reset_ready", {31'h0, o_cmd_ready}, 32'h0);
    check("reset_status", o_status, 32'h1);

    power_up();
    send(1'b1, 8'h41, 17);
    send(1'b0, 8'h01, 47);
    send(1'b1, 8'h01, 17);
    held_valid();
    reset_mid_en();
    send(1'b1, 8'h41, 17);
    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Timed HD44780-style character-LCD write controller, directly downstream of the LSU's LCD IO register path.
- Software issues commands and characters as single-cycle requests. The block generates the setup, enable-pulse, hold and execution-wait timing, and runs the power-up initialisation sequence itself.
- It exposes a busy/init status word for the LSU read-back mux, so firmware never bit-bangs EN.

Parameters:
- SETUP_CYC, 4: cycles from data/RS valid to EN rising.
- EN_CYC, 12: EN high width in cycles.
- HOLD_CYC, 4: cycles after EN falls before the execution wait starts.
- EXEC_CYC, 2000: execution wait for ordinary commands and data (40 us at 50 MHz).
- CLEAR_CYC, 82000: execution wait for clear/home (1.64 ms).
- PWRUP_CYC, 750000: wait after reset before the first init command (15 ms).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_cmd_valid  in  1  request strobe (LCD register write decoded by the LSU).
- i_cmd_rs  in  1  0 = instruction, 1 = character data.
- i_cmd_data  in  8  byte to write.
- o_cmd_ready  out  1  request accepted on the edge where valid and ready are both high.
- i_lcd_on  in  1  backlight/power request level.
- o_lcd_data  out  8  LCD DB[7:0].
- o_lcd_rs  out  1  LCD RS.
- o_lcd_rw  out  1  LCD RW, constant 0 (write-only).
- o_lcd_en  out  1  LCD E.
- o_lcd_on  out  1  registered copy of i_lcd_on.
- o_status  out  32  {30'b0, init_done, busy}, where busy = ~o_cmd_ready.

Behaviour:
- Reset values (while i_reset=0): o_lcd_data=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_en=0, o_lcd_on=0, o_cmd_ready=0, init_done=0, busy=1. State is PWRUP.
- State machine:
  - PWRUP counts PWRUP_CYC cycles, then goes to INIT_LOAD.
  - INIT_LOAD drives the next init command with RS=0. The sequence is 0x38, 0x0C, 0x01, 0x06, in order, then goes to SETUP.
  - IDLE: o_cmd_ready=1 only here, and only when init_done=1.
  - SETUP (SETUP_CYC cycles) → EN_HIGH (EN_CYC cycles) → HOLD (HOLD_CYC cycles) → EXEC_WAIT.
  - EXEC_WAIT counts CLEAR_CYC if RS=0 and data is 0x01, 0x02 or 0x03; otherwise it counts EXEC_CYC.
  - On leaving EXEC_WAIT: if init commands remain, go to INIT_LOAD. If the 4th init command just completed, set init_done and go to IDLE. Otherwise go to IDLE.
- Acceptance timing, with the accepting edge called E0:
  - o_lcd_data and o_lcd_rs take the request at E0 and hold until the next acceptance.
  - o_lcd_en rises at edge E0+SETUP_CYC and falls at E0+SETUP_CYC+EN_CYC.
  - o_cmd_ready rises at edge E0+SETUP_CYC+EN_CYC+HOLD_CYC+WAIT, where WAIT is EXEC_CYC or CLEAR_CYC.
  - Init commands follow identical timing, with E0 being the INIT_LOAD edge.
- Handshake rules:
  - Exactly one EN pulse per accepted command.
  - i_cmd_valid while not ready is ignored and not queued; the producer must hold or retry. The LSU firmware polls o_status[0].
  - Data and RS never change while EN is high or during HOLD.
- Clear/home detection applies only when RS=0. RS=1 with data 0x01 uses EXEC_CYC.
- o_lcd_on: registered from i_lcd_on every cycle, independent of the FSM.
- Reset mid-operation: all outputs return asynchronously to reset values, including EN dropping immediately. The FSM restarts at PWRUP and repeats the full init sequence.
- Counters: a single down-counter, width $clog2(max parameter + 1). It loads N-1 on state entry and the state exits when it reaches 0. All parameters must be ≥1.

Decomposition:
- lcd_pkg holds:
  - state enum lcd_state_t: PWRUP, INIT_LOAD, IDLE, SETUP, EN_HIGH, HOLD, EXEC_WAIT;
  - init-sequence constant array LCD_INIT_SEQ[4] = {8'h38, 8'h0C, 8'h01, 8'h06};
  - opcode constants LCD_CLEAR=8'h01 and LCD_HOME=8'h02.
- One sub-module, lcd_timer: loadable down-counter with load value, load strobe and done flag.

Test Plan (overrides: SETUP=2, EN=3, HOLD=2, EXEC=10, CLEAR=40, PWRUP=20):
1. Release reset → all outputs 0 and o_status=32'h1. After 20 cycles, four EN pulses carry 0x38, 0x0C, 0x01, 0x06 with RS=0. The pulse after 0x01 is followed by a 40-cycle wait, and o_status becomes 32'h2 (ready) after the 4th wait.
2. After init, send RS=1, data 0x41 → EN high on edges E0+2..E0+5, then o_cmd_ready reasserts at E0+17.
3. Send RS=0, data 0x01 → ready returns at E0+47. Send RS=1, data 0x01 → ready returns at E0+17.
4. Hold i_cmd_valid with 0x42 continuously from E0 → exactly one pulse per ready window. Data stays at 0x41 until the next acceptance, then becomes 0x42.
5. Assert i_reset=0 mid EN_HIGH → o_lcd_en=0 with no clock edge, o_status=32'h1. After release, the full 20-cycle power-up and init sequence repeats.
6. Pulse i_cmd_valid during init and toggle i_lcd_on → no extra EN pulse and init bytes unchanged; o_lcd_on follows i_lcd_on one cycle later.
